// File: rtl/imem_stream_loader_if.sv
`timescale 1ns/1ps
// imem_stream_loader_if: fetch and boot-loader signal bundle for imem_stream_loader
// master: fetch stage / download bridge side; slave: instruction memory side.
interface imem_stream_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 14
);
  logic              fetch_en;
  logic [ADDR_W-1:0] read_address;
  logic [DATA_W-1:0] instruction;
  logic              inst_valid;
  logic              fetch_err;
  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [CNT_W-1:0]  load_count;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              load_busy;
  logic              load_done;
  modport master (
    output fetch_en, read_address, load_start, load_base, load_count, ld_valid, ld_data,
    input  instruction, inst_valid, fetch_err, ld_ready, load_busy, load_done
  );
  modport slave (
    input  fetch_en, read_address, load_start, load_base, load_count, ld_valid, ld_data,
    output instruction, inst_valid, fetch_err, ld_ready, load_busy, load_done
  );
endinterface

// File: rtl/imem_stream_loader.sv
`timescale 1ns/1ps
// imem_stream_loader: word-organised instruction memory with registered fetch port and streaming loader
// Ports: clock, reset_n (async active-low), bus (slave): fetch_en/read_address -> instruction/inst_valid/fetch_err,
// load_start/load_base/load_count + ld_valid/ld_data/ld_ready stream -> load_busy/load_done.
module imem_stream_loader #(
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 8192,
  parameter int              ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input logic                 clock,
  input logic                 reset_n,
  imem_stream_loader_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
  state_t            state, state_nx;
  logic [AW-1:0]     wptr, fidx;
  logic [CW-1:0]     rem;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] instr_q;
  logic              valid_q, err_q;
  logic              hs, fetch_ok, fetch_bad;
  always_comb begin
    hs       = (state == LOAD) && bus.ld_valid;
    state_nx = (state == IDLE && bus.load_start) ? ((bus.load_count == '0) ? DONE : LOAD) :
               (hs && rem == CW'(1))             ? DONE :
               (state == DONE)                   ? IDLE : state;
  end
  // Fetches are refused while the array is being rewritten.
  assign fetch_ok  = bus.fetch_en && (state != LOAD);
  assign fidx      = AW'(bus.read_address >> 2);
  assign fetch_bad = (|bus.read_address[1:0]) || ((bus.read_address >> (AW + 2)) != '0);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      wptr  <= '0;
      rem   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.load_start) begin
        wptr <= AW'(bus.load_base >> 2);
        rem  <= bus.load_count;
      end else if (hs) begin
        wptr <= wptr + AW'(1);
        rem  <= rem - CW'(1);
      end
    end
  end
  always_ff @(posedge clock) begin
    if (hs) mem[wptr] <= bus.ld_data;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= fetch_ok;
      if (fetch_ok) begin
        instr_q <= fetch_bad ? NOP_WORD : mem[fidx];
        err_q   <= fetch_bad;
      end
    end
  end
  assign bus.instruction = instr_q;
  assign bus.inst_valid  = valid_q;
  assign bus.fetch_err   = err_q;
  assign bus.ld_ready    = state == LOAD;
  assign bus.load_busy   = state == LOAD;
  assign bus.load_done   = state == DONE;
endmodule

// File: tb/tb_imem_stream_loader.sv
`timescale 1ns/1ps
// tb_imem_stream_loader: scoreboard bench for imem_stream_loader
module tb_imem_stream_loader;
  localparam int DEPTH = 128;
  localparam int AW    = $clog2(DEPTH);
  logic clock = 0;
  logic reset_n = 0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] model [DEPTH];
  logic [32:0] q [$];
  imem_stream_loader_if #(.DATA_W(32), .ADDR_W(32), .CNT_W(AW + 1)) bus ();
  imem_stream_loader #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .NOP_WORD(32'h0)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus.slave)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  task automatic fetch(input logic [31:0] a);
    logic bad;
    bad = (a[1:0] != 0) || (a >= DEPTH * 4);
    bus.fetch_en = 1;
    bus.read_address = a;
    q.push_back({bad, bad ? 32'h0 : model[(a >> 2) % DEPTH]});
    tick;
    bus.fetch_en = 0;
  endtask
  task automatic do_load(input int base, input int cnt, input int data0, input bit toggle,
                         input int abort_at, input int exp_ready);
    int i = 0, rdy = 0, blk = 0, cyc = 0;
    int w = (base >> 2) % DEPTH;
    bit ph = 1;
    bus.load_start = 1;
    bus.load_base  = base;
    bus.load_count = cnt[AW:0];
    tick;
    bus.load_start = 0;
    bus.fetch_en = 1;
    bus.read_address = 32'h100;
    while (i < cnt && i < abort_at && cyc < 200) begin
      bus.ld_valid = toggle ? ph : 1'b1;
      bus.ld_data  = data0 + i;
      ph = !ph;
      bus.load_start = (cyc == 1);
      bus.load_count = 1;
      if (bus.ld_ready) rdy++;
      if (bus.ld_valid && bus.ld_ready) begin
        model[w] = data0 + i;
        w = (w + 1) % DEPTH;
        i++;
      end
      tick;
      cyc++;
      if (bus.inst_valid) blk++;
    end
    bus.ld_valid = 0;
    bus.load_start = 0;
    bus.fetch_en = 0;
    if (cyc >= 200) chk("load_timeout", i, cnt);
    chk("blocked_valid", blk, 0);
    if (i < abort_at) begin
      chk("ready_cycles", rdy, exp_ready);
      chk("done_pulse", bus.load_done, 1);
      chk("done_ready", bus.ld_ready, 0);
      tick;
      chk("done_clear", bus.load_done, 0);
      chk("idle_busy", bus.load_busy, 0);
    end
  endtask
  always @(posedge clock) begin
    #2;
    if (reset_n && bus.inst_valid) begin
      if (q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        logic [32:0] e;
        e = q.pop_front();
        chk("fetch_data", bus.instruction, e[31:0]);
        chk("fetch_err", bus.fetch_err, e[32]);
      end
    end
  end
  initial begin
    bus.fetch_en = 0; bus.read_address = 0; bus.load_start = 0; bus.load_base = 0;
    bus.load_count = 0; bus.ld_valid = 0; bus.ld_data = 0;
    repeat (3) tick;
    chk("rst_instr", bus.instruction, 0);
    chk("rst_valid", bus.inst_valid, 0);
    chk("rst_ready", bus.ld_ready, 0);
    chk("rst_busy", bus.load_busy, 0);
    chk("rst_done", bus.load_done, 0);
    reset_n = 1;
    tick;
    do_load(0, 6, 32'h5000, 0, 1000, 6);
    do_load(32'h100, 4, 32'hA0, 0, 1000, 4);
    fetch(32'h100);
    fetch(32'h104);
    fetch(32'h10C);
    tick;
    do_load((DEPTH - 2) * 4, 4, 32'hC0, 1, 1000, 7);
    for (int k = 0; k < 4; k++) fetch((DEPTH - 2) * 4 + k * 4);
    fetch(32'h0);
    fetch(32'h8);
    fetch(32'h102);
    fetch(DEPTH * 4);
    fetch(32'h100);
    tick;
    do_load(32'h100, 0, 32'hEE, 0, 1000, 0);
    fetch(32'h100);
    tick;
    do_load(0, 6, 32'hD0, 0, 3, 0);
    chk("mid_busy", bus.load_busy, 1);
    reset_n = 0;
    #1;
    chk("arst_instr", bus.instruction, 0);
    chk("arst_valid", bus.inst_valid, 0);
    chk("arst_ready", bus.ld_ready, 0);
    chk("arst_busy", bus.load_busy, 0);
    chk("arst_done", bus.load_done, 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("arst_no_done", bus.load_done, 0);
    end
    reset_n = 1;
    tick;
    chk("post_rst_done", bus.load_done, 0);
    for (int k = 0; k < 6; k++) fetch(k * 4);
    for (int k = 0; k < 10 && q.size() != 0; k++) tick;
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
- Parametrised instruction memory for the MIPS core.
- Byte-addressed, word-organised storage with a registered 1-cycle fetch port and a streaming boot-loader port.
- Loader uses a valid/ready handshake driven by a load FSM; the fetch port is blocked while a load is in progress.
- Sits between the PC/fetch stage and the program-download path (UART/JTAG bridge).

Parameters:
- DATA_W, 32, instruction/data word width in bits.
- DEPTH, 8192, number of words; must be a power of two ≥ 2.
- ADDR_W, 32, byte-address width of the fetch and load-base ports.
- NOP_WORD, 32'h00000000, value driven on `instruction` for a rejected fetch.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  fetch request this cycle.
- read_address  in  ADDR_W  fetch byte address.
- instruction  out  DATA_W  fetched word, registered.
- inst_valid  out  1  `instruction` is valid (1 cycle after an accepted fetch).
- fetch_err  out  1  registered; previous fetch was misaligned or out of range.
- load_start  in  1  start a load (sampled in IDLE only).
- load_base  in  ADDR_W  byte address of the first word to load.
- load_count  in  log2(DEPTH)+1  number of words to load.
- ld_valid  in  1  ld_data is valid.
- ld_data  in  DATA_W  word to write.
- ld_ready  out  1  loader accepts a word.
- load_busy  out  1  FSM is in LOAD.
- load_done  out  1  one-cycle pulse when a load completes.

Behaviour:
- Reset values (asynchronous, reset_n=0):
  - FSM=IDLE, word counter=0, remaining=0.
  - instruction=NOP_WORD; inst_valid, fetch_err, ld_ready, load_busy, load_done = 0.
  - Memory array is not reset.
- Addressing:
  - word index = address[log2(DEPTH)+1:2].
  - Misaligned if address[1:0]≠0.
  - Out of range if address ≥ DEPTH*4.
- Fetch, allowed only in IDLE or DONE:
  - An accepted fetch (fetch_en=1, not LOAD) registers on the next edge: inst_valid=1.
  - Good address: instruction=mem[index], fetch_err=0.
  - Misaligned or out-of-range address: instruction=NOP_WORD, fetch_err=1.
  - Cycles with no accepted fetch: inst_valid=0; instruction and fetch_err hold.
  - fetch_en in LOAD is ignored: inst_valid=0.
- FSM states: IDLE, LOAD, DONE.
  - IDLE→LOAD when load_start=1 and load_count≠0. Latch wptr=load_base word index and remaining=load_count.
  - IDLE→DONE when load_start=1 and load_count=0 (no writes).
  - LOAD: ld_ready=1 and load_busy=1. A handshake (ld_valid & ld_ready) writes mem[wptr]=ld_data, sets wptr=(wptr+1) mod DEPTH (wraps to 0 past DEPTH-1), and decrements remaining.
  - The write whose remaining=1 goes to DONE; no further words are accepted that cycle.
  - LOAD with ld_valid=0: wait indefinitely, no timeout.
  - DONE: load_done=1 for exactly one cycle, ld_ready=0, then →IDLE.
  - load_start in LOAD or DONE is ignored.
  - A misaligned load_base has its low bits dropped; out-of-range upper bits are dropped, giving a modulo base.
- Write/read ordering:
  - Fetches cannot overlap writes, so no read-during-write case exists.
  - The first fetch after DONE returns the newly loaded data.
- Reset mid-load: FSM→IDLE immediately, already-written words persist, partial words discarded, no load_done pulse.
- Registers updated only on the clock edge; no combinational path from fetch inputs to `instruction`.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles mid-operation → instruction=0, inst_valid=0, ld_ready=0, load_busy=0, load_done=0 immediately (asynchronous).
- Basic load+fetch:
  - Stimulus: load_base=0x100, load_count=4, words 0xA0..0xA3 with ld_valid held high.
  - Required: ld_ready high 4 cycles; load_done pulses on cycle 5 (DONE state).
  - Then fetch 0x100, 0x104, 0x10C → instruction 0xA0, 0xA1, 0xA3, each with inst_valid=1 one cycle later.
- Backpressure and wrap:
  - Stimulus: load_base=(DEPTH-2)*4, load_count=4, ld_valid toggling 1,0,1,0….
  - Required: exactly 4 writes, landing at indices DEPTH-2, DEPTH-1, 0, 1.
  - Then fetch address 0 → 3rd word.
- Fetch errors:
  - Fetch 0x102 → instruction=0, fetch_err=1, inst_valid=1.
  - Fetch DEPTH*4 → same response.
  - Fetch 0x100 → fetch_err=0.
- Blocking and zero count:
  - fetch_en held during LOAD → inst_valid=0 throughout.
  - load_start while busy → ignored; the count is not reloaded.
  - load_count=0 → load_done pulses the next cycle, memory unchanged.
- Reset mid-load:
  - Stimulus: start a 6-word load, write 3 words, then assert reset_n=0.
  - Required: no load_done pulse; words 0..2 retained; words 3..5 keep their old contents.
